// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception controller: codes, CP0 addresses, field positions.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
    localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;

    localparam int EXCF_SYSCALL = 8;
    localparam int EXCF_INVALID = 9;
    localparam int EXCF_TRAP    = 10;
    localparam int EXCF_OV      = 11;
    localparam int EXCF_ERET    = 12;

    localparam logic [31:0] EXC_NONE    = 32'h0;
    localparam logic [31:0] EXC_INT     = 32'h1;
    localparam logic [31:0] EXC_SYSCALL = 32'h8;
    localparam logic [31:0] EXC_INVALID = 32'ha;
    localparam logic [31:0] EXC_TRAP    = 32'hd;
    localparam logic [31:0] EXC_OV      = 32'hc;
    localparam logic [31:0] EXC_ERET    = 32'he;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } exc_state_e;

endpackage

// File: rtl/cp0_exc_ctrl_fwd.sv
// Combinational bypass of an in-flight WB write onto the Status/Cause/EPC values read by MEM.
// Only the software-writable Cause bits (IP1..IP0 and IV/WP) are taken from the WB data.
module cp0_fwd
    import cp0_exc_ctrl_pkg::*;
(
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o
);

    always_comb begin
        status_o = cp0_status_i;
        cause_o  = cp0_cause_i;
        epc_o    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == CP0_ADDR_STATUS) status_o = wb_cp0_wdata_i;
            if (wb_cp0_waddr_i == CP0_ADDR_CAUSE) begin
                cause_o[9:8]   = wb_cp0_wdata_i[9:8];
                cause_o[23:22] = wb_cp0_wdata_i[23:22];
            end
            if (wb_cp0_waddr_i == CP0_ADDR_EPC) epc_o = wb_cp0_wdata_i;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// MEM-stage exception arbiter: picks one prioritized exception, strobes it to CP0 the same cycle,
// then holds flush_o for FLUSH_CYCLES cycles with the redirect PC; stall_i defers the commit.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_excflags_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delay_i,
    input  logic        stall_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_in_delay_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        int_pending_o,
    output logic [31:0] exc_count_o
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    logic [31:0] status_fwd, cause_fwd, epc_fwd;
    logic        int_req;
    logic [31:0] cand;
    logic        commit;

    exc_state_e  state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        int_pending_q, int_pending_d;
    logic [31:0] exc_count_q, exc_count_d;
    logic        unused_bits;

    cp0_fwd u_fwd (
        .cp0_status_i   (cp0_status_i),
        .cp0_cause_i    (cp0_cause_i),
        .cp0_epc_i      (cp0_epc_i),
        .wb_cp0_we_i    (wb_cp0_we_i),
        .wb_cp0_waddr_i (wb_cp0_waddr_i),
        .wb_cp0_wdata_i (wb_cp0_wdata_i),
        .status_o       (status_fwd),
        .cause_o        (cause_fwd),
        .epc_o          (epc_fwd)
    );

    assign unused_bits = ^{mem_excflags_i[31:13], mem_excflags_i[7:0], status_fwd[31:16],
                           status_fwd[7:2], cause_fwd[31:16], cause_fwd[7:0]};

    assign int_req = (|(cause_fwd[15:8] & status_fwd[15:8])) && status_fwd[STATUS_IE_BIT]
                     && !status_fwd[STATUS_EXL_BIT];

    always_comb begin
        cand = EXC_NONE;
        if (state_q == ST_IDLE && !stall_i && mem_pc_i != 32'h0) begin
            if (int_req || int_pending_q)          cand = EXC_INT;
            else if (mem_excflags_i[EXCF_SYSCALL]) cand = EXC_SYSCALL;
            else if (mem_excflags_i[EXCF_INVALID]) cand = EXC_INVALID;
            else if (mem_excflags_i[EXCF_TRAP])    cand = EXC_TRAP;
            else if (mem_excflags_i[EXCF_OV])      cand = EXC_OV;
            else if (mem_excflags_i[EXCF_ERET])    cand = EXC_ERET;
        end
    end

    assign commit = (cand != EXC_NONE);

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        flush_d       = flush_q;
        new_pc_d      = new_pc_q;
        exc_count_d   = exc_count_q;
        int_pending_d = int_pending_q;
        if (!stall_i) begin
            if (cand == EXC_INT || !int_req) int_pending_d = 1'b0;
            else if (mem_pc_i == 32'h0)      int_pending_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                    flush_d     = 1'b1;
                    new_pc_d    = (cand == EXC_ERET) ? epc_fwd : EXC_VECTOR;
                    exc_count_d = exc_count_q + 32'd1;
                end
            end
            ST_FLUSH: begin
                // Flush length is fixed once committed; stalls do not stretch it.
                if (flush_cnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                    flush_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            flush_cnt_q   <= 2'd0;
            flush_q       <= 1'b0;
            new_pc_q      <= 32'h0;
            int_pending_q <= 1'b0;
            exc_count_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            flush_q       <= flush_d;
            new_pc_q      <= new_pc_d;
            int_pending_q <= int_pending_d;
            exc_count_q   <= exc_count_d;
        end
    end

    assign excepttype_o   = cand;
    assign exc_pc_o       = mem_pc_i;
    assign exc_in_delay_o = mem_in_delay_i;
    assign flush_o        = flush_q;
    assign new_pc_o       = new_pc_q;
    assign int_pending_o  = int_pending_q;
    assign exc_count_o    = exc_count_q;

endmodule
